// File: rtl/srgate_sched.sv
// Timed command scheduler: queues (ts, gate, op, arg) commands and fires each when the timebase reaches ts.
// Latency: push in cycle N, head eligible in N+1, registered effect visible in N+2 when already due.
// Backpressure: cmd_ready_o drops when the queue holds DEPTH entries; pushes while full are dropped.
module srgate_sched #(
    parameter int NGATES = 4,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       enable_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [TS_W-1:0]            cmd_ts_i,
    input  logic [$clog2(NGATES)-1:0]  cmd_gate_i,
    input  logic [1:0]                 cmd_op_i,
    input  logic                       cmd_arg_i,
    output logic [NGATES-1:0]          force_set_o,
    output logic [NGATES-1:0]          force_rst_o,
    output logic [NGATES-1:0]          set_edge_o,
    output logic [NGATES-1:0]          rst_edge_o,
    output logic [TS_W-1:0]            ts_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       late_o,
    output logic                       busy_o
);

    localparam int GW = $clog2(NGATES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OP_FRST = 2'b00;
    localparam logic [1:0] OP_FSET = 2'b01;
    localparam logic [1:0] OP_SEDG = 2'b10;

    // Head-of-queue state: EMPTY has no entry, WAIT holds a not-yet-due head,
    // FIRE holds a head right after a pop (so a run of due commands stays in FIRE).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [GW-1:0]   gate;
        logic [1:0]      op;
        logic            arg;
    } cmd_t;

    cmd_t              mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    state_t            state_q;
    state_t            state_d;
    logic [TS_W-1:0]   ts_q;
    logic              late_q;
    logic              late_d;
    logic [NGATES-1:0] force_set_q;
    logic [NGATES-1:0] force_set_d;
    logic [NGATES-1:0] force_rst_q;
    logic [NGATES-1:0] force_rst_d;
    logic [NGATES-1:0] set_edge_q;
    logic [NGATES-1:0] set_edge_d;
    logic [NGATES-1:0] rst_edge_q;
    logic [NGATES-1:0] rst_edge_d;

    cmd_t head;
    logic push;
    logic pop;

    assign head        = mem_q[rd_ptr_q];
    assign cmd_ready_o = (count_q != CW'(DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;

    // Timebase: free-running while enabled, held at zero while disabled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts_q <= '0;
        end else if (enable_i) begin
            ts_q <= ts_q + TS_W'(1);
        end else begin
            ts_q <= '0;
        end
    end

    // Queue storage: entries need no reset, validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{ts: cmd_ts_i, gate: cmd_gate_i, op: cmd_op_i, arg: cmd_arg_i};
        end
    end

    // Head FSM next state, pop decision and occupancy update.
    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_WAIT, ST_FIRE: pop = enable_i && (ts_q >= head.ts);
            default:          pop = 1'b0;
        endcase
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (pop) begin
            state_d = ST_FIRE;
        end else begin
            state_d = ST_WAIT;
        end
    end

    // Effect decode for the popped command; strobes default low every cycle.
    always_comb begin
        force_set_d = '0;
        force_rst_d = '0;
        set_edge_d  = set_edge_q;
        rst_edge_d  = rst_edge_q;
        late_d      = late_q;
        if (pop) begin
            if (ts_q > head.ts) begin
                late_d = 1'b1;
            end
            case (head.op)
                OP_FRST: force_rst_d[head.gate] = 1'b1;
                OP_FSET: force_set_d[head.gate] = 1'b1;
                OP_SEDG: set_edge_d[head.gate]  = head.arg;
                default: rst_edge_d[head.gate]  = head.arg;
            endcase
        end
    end

    // Control and output registers; reset discards queued commands and any pending strobe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_EMPTY;
            late_q      <= 1'b0;
            force_set_q <= '0;
            force_rst_q <= '0;
            set_edge_q  <= '0;
            rst_edge_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_d;
            state_q     <= state_d;
            late_q      <= late_d;
            force_set_q <= force_set_d;
            force_rst_q <= force_rst_d;
            set_edge_q  <= set_edge_d;
            rst_edge_q  <= rst_edge_d;
        end
    end

    assign force_set_o = force_set_q;
    assign force_rst_o = force_rst_q;
    assign set_edge_o  = set_edge_q;
    assign rst_edge_o  = rst_edge_q;
    assign ts_o        = ts_q;
    assign count_o     = count_q;
    assign late_o      = late_q;
    assign busy_o      = (count_q != '0);

endmodule
